// File: rtl/mnist_pkg.sv
// Shared constants and FSM encoding for the MNIST argmax sequencing stage.
package mnist_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH   = 4;
  localparam int CNT_WIDTH   = 16;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SCAN, DONE} argmax_state_t;
endpackage

// File: rtl/argmax_acc.sv
// Running signed maximum and its index. Strict compare keeps the lowest index on ties.
module argmax_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_init,
  input  logic                         i_upd,
  input  logic                         i_clr,
  input  logic signed [DATA_WIDTH-1:0] i_score,
  input  logic        [IDX_WIDTH-1:0]  i_idx,
  output logic        [IDX_WIDTH-1:0]  o_best_idx,
  output logic signed [DATA_WIDTH-1:0] o_nxt_score,
  output logic        [IDX_WIDTH-1:0]  o_nxt_idx
);
  logic signed [DATA_WIDTH-1:0] r_best_score;
  logic        [IDX_WIDTH-1:0]  r_best_idx;

  // Next value is exposed so the final element can be folded into a result on the same edge.
  always_comb begin
    o_nxt_score = r_best_score;
    o_nxt_idx   = r_best_idx;
    if (i_clr) begin
      o_nxt_score = '0;
      o_nxt_idx   = '0;
    end else if (i_init) begin
      o_nxt_score = i_score;
      o_nxt_idx   = i_idx;
    end else if (i_upd && (i_score > r_best_score)) begin
      o_nxt_score = i_score;
      o_nxt_idx   = i_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_score <= '0;
      r_best_idx   <= '0;
    end else begin
      r_best_score <= o_nxt_score;
      r_best_idx   <= o_nxt_idx;
    end
  end

  assign o_best_idx = r_best_idx;
endmodule

// File: rtl/mnist_argmax_ctrl.sv
// Launches one inference, scans the class scores via the engine read port and
// reports the argmax, with saturating classification/accuracy counters.
module mnist_argmax_ctrl #(
  parameter int DATA_WIDTH  = mnist_pkg::DATA_WIDTH,
  parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
  parameter int CNT_WIDTH   = mnist_pkg::CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [3:0]                   label,
  input  logic                         clear_stats,
  output logic                         busy,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [3:0]                   eng_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_score,
  output logic                         result_valid,
  output logic [3:0]                   result_digit,
  output logic signed [DATA_WIDTH-1:0] result_score,
  output logic [CNT_WIDTH-1:0]         total_cnt,
  output logic [CNT_WIDTH-1:0]         correct_cnt
);
  import mnist_pkg::*;

  argmax_state_t r_state, w_nxt_state;
  logic                         r_armed;
  logic [IDX_WIDTH-1:0]         r_label;
  logic [IDX_WIDTH-1:0]         r_idx;
  logic                         r_eng_start, r_busy, r_valid;
  logic [IDX_WIDTH-1:0]         r_digit;
  logic signed [DATA_WIDTH-1:0] r_score;
  logic [CNT_WIDTH-1:0]         r_total, r_correct;

  logic                         w_accept, w_scan, w_last;
  logic [IDX_WIDTH-1:0]         w_best_idx, w_nxt_idx;
  logic signed [DATA_WIDTH-1:0] w_nxt_score;

  assign w_accept = (r_state == IDLE) && start;
  assign w_scan   = (r_state == SCAN);
  assign w_last   = (r_idx == IDX_WIDTH'(NUM_CLASSES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:    if (start) w_nxt_state = LAUNCH;
      LAUNCH:  w_nxt_state = WAIT;
      WAIT:    if (r_armed && eng_done) w_nxt_state = SCAN;
      SCAN:    if (w_last) w_nxt_state = DONE;
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  argmax_acc #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_init      (w_scan && (r_idx == '0)),
    .i_upd       (w_scan),
    .i_clr       (w_accept),
    .i_score     (eng_score),
    .i_idx       (r_idx),
    .o_best_idx  (w_best_idx),
    .o_nxt_score (w_nxt_score),
    .o_nxt_idx   (w_nxt_idx)
  );

  // armed only after done has been seen low, so a level left over from the last run is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_label     <= '0;
      r_idx       <= '0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_digit     <= '0;
      r_score     <= '0;
    end else begin
      if (r_state == LAUNCH)                 r_armed <= 1'b0;
      else if (r_state == WAIT && !eng_done) r_armed <= 1'b1;
      if (w_accept) r_label <= label;
      r_idx       <= (w_scan && !w_last) ? r_idx + 1'b1 : '0;
      r_eng_start <= w_accept;
      r_busy      <= (w_nxt_state != IDLE);
      r_valid     <= w_scan && w_last;
      if (w_scan && w_last) begin
        r_digit <= w_nxt_idx;
        r_score <= w_nxt_score;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (r_state == DONE) begin
      if (r_total != '1) r_total <= r_total + 1'b1;
      if ((w_best_idx == r_label) && (r_correct != '1)) r_correct <= r_correct + 1'b1;
    end
  end

  assign busy         = r_busy;
  assign eng_start    = r_eng_start;
  assign eng_idx      = r_idx;
  assign result_valid = r_valid;
  assign result_digit = r_digit;
  assign result_score = r_score;
  assign total_cnt    = r_total;
  assign correct_cnt  = r_correct;
endmodule
